// File: rtl/slice_reg_cfg_model.sv
// SLICE REG0/REG1 config-frame decoder with a cycle-accurate model
// of the two slice flip-flops running under the applied config.
module slice_reg_cfg_model #(
  parameter logic [7:0] HEADER   = 8'hA5,
  parameter logic [7:0] INIT_CFG = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  input  logic [7:0] cfg_data,
  output logic       cfg_loaded,
  output logic       cfg_err,
  output logic [7:0] cfg_q,
  input  logic [1:0] di,
  input  logic [1:0] m,
  input  logic       ce,
  input  logic       lsr,
  input  logic       gsr,
  output logic [1:0] q
);

  typedef enum logic [1:0] {
    S_HDR,
    S_CFG,
    S_CHK,
    S_APPLY
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [7:0] r_shadow;
  logic [7:0] r_cfg;
  logic       r_err;
  logic [1:0] r_q;

  logic       w_acc;
  logic       w_chk_ok;
  logic       w_err_set;

  logic [1:0] w_regset;
  logic [1:0] w_sel;
  logic [1:0] w_prld;
  logic       w_gsr_en;
  logic       w_async;
  logic [1:0] w_lsr_val;
  logic [1:0] w_q_nxt;

  assign w_acc    = cfg_valid & cfg_ready;
  assign w_chk_ok = (cfg_data == (HEADER ^ r_shadow));

  always_comb begin
    w_next    = r_state;
    w_err_set = 1'b0;
    unique case (r_state)
      S_HDR: begin
        if (w_acc && cfg_data == HEADER)
          w_next = S_CFG;
      end
      S_CFG: begin
        if (w_acc)
          w_next = S_CHK;
      end
      S_CHK: begin
        if (w_acc) begin
          if (w_chk_ok) begin
            w_next = S_APPLY;
          end else begin
            w_next    = S_HDR;
            w_err_set = 1'b1;
          end
        end
      end
      S_APPLY: begin
        w_next = S_HDR;
      end
    endcase
  end

  // Handshake outputs are forced low while rst is held.
  assign cfg_ready  = ~rst & (r_state != S_APPLY);
  assign cfg_loaded = ~rst & (r_state == S_APPLY);
  assign cfg_err    = ~rst & r_err;
  assign cfg_q      = r_cfg;

  assign w_regset = {r_cfg[3], r_cfg[0]};
  assign w_sel    = {r_cfg[4], r_cfg[1]};
  assign w_prld   = {r_cfg[5], r_cfg[2]};
  assign w_gsr_en = r_cfg[6];
  assign w_async  = r_cfg[7];

  always_comb begin
    w_lsr_val = 2'b00;
    w_q_nxt   = r_q;
    for (int k = 0; k < 2; k++) begin
      w_lsr_val[k] = w_prld[k] ? m[k] : w_regset[k];
      if (gsr && w_gsr_en)
        w_q_nxt[k] = w_regset[k];
      else if (lsr)
        w_q_nxt[k] = w_lsr_val[k];
      else if (ce)
        w_q_nxt[k] = w_sel[k] ? m[k] : di[k];
    end
  end

  assign q = (w_async && lsr) ? w_lsr_val : r_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_HDR;
      r_shadow <= INIT_CFG;
      r_cfg    <= INIT_CFG;
      r_err    <= 1'b0;
      r_q      <= {INIT_CFG[3], INIT_CFG[0]};
    end else begin
      r_state <= w_next;
      r_err   <= w_err_set;
      r_q     <= w_q_nxt;
      if (r_state == S_CFG && w_acc)
        r_shadow <= cfg_data;
      // FFs see the new config only from the cycle after APPLY.
      if (r_state == S_APPLY)
        r_cfg <= r_shadow;
    end
  end

endmodule

// File: tb/tb_slice_reg_cfg_model.sv
// Directed bench for slice_reg_cfg_model: frame parsing and
// flip-flop priority/mode behaviour with hand-computed results.
module tb_slice_reg_cfg_model;

  logic       clk;
  logic       rst;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [7:0] cfg_data;
  logic       cfg_loaded;
  logic       cfg_err;
  logic [7:0] cfg_q;
  logic [1:0] di;
  logic [1:0] m;
  logic       ce;
  logic       lsr;
  logic       gsr;
  logic [1:0] q;

  int n_run;
  int n_fail;

  slice_reg_cfg_model #(
    .HEADER  (8'hA5),
    .INIT_CFG(8'h00)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_data  (cfg_data),
    .cfg_loaded(cfg_loaded),
    .cfg_err   (cfg_err),
    .cfg_q     (cfg_q),
    .di        (di),
    .m         (m),
    .ce        (ce),
    .lsr       (lsr),
    .gsr       (gsr),
    .q         (q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [7:0] got,
                     input logic [7:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic send(input logic [7:0] b);
    cfg_valid = 1'b1;
    cfg_data  = b;
    @(negedge clk);
    cfg_valid = 1'b0;
    cfg_data  = 8'h00;
  endtask

  task automatic load_cfg(input string tag, input logic [7:0] c);
    send(8'hA5);
    send(c);
    send(8'hA5 ^ c);
    chk({tag, "_loaded"}, {7'd0, cfg_loaded}, 8'd1);
    chk({tag, "_ready_apply"}, {7'd0, cfg_ready}, 8'd0);
    @(negedge clk);
    chk({tag, "_cfg_q"}, cfg_q, c);
  endtask

  initial begin
    n_run     = 0;
    n_fail    = 0;
    rst       = 1'b1;
    cfg_valid = 1'b0;
    cfg_data  = 8'h00;
    di        = 2'b00;
    m         = 2'b00;
    ce        = 1'b0;
    lsr       = 1'b0;
    gsr       = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ready", {7'd0, cfg_ready}, 8'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", {7'd0, cfg_ready}, 8'd1);
    chk("rst_cfg_q", cfg_q, 8'h00);
    chk("rst_q", {6'd0, q}, 8'h00);
    chk("rst_loaded", {7'd0, cfg_loaded}, 8'd0);
    @(negedge clk);

    // 1: bad checksum then good frame
    send(8'hA5);
    send(8'h05);
    send(8'hA1);
    chk("bad_err", {7'd0, cfg_err}, 8'd1);
    chk("bad_loaded", {7'd0, cfg_loaded}, 8'd0);
    @(negedge clk);
    chk("bad_err_clr", {7'd0, cfg_err}, 8'd0);
    chk("bad_cfg_q", cfg_q, 8'h00);
    load_cfg("good05", 8'h05);

    // 2: DF path and hold
    load_cfg("c00", 8'h00);
    ce = 1'b1;
    di = 2'b10;
    @(negedge clk);
    chk("ce_di", {6'd0, q}, 8'h02);
    ce = 1'b0;
    di = 2'b01;
    @(negedge clk);
    chk("hold", {6'd0, q}, 8'h02);

    // 3: LSR reset-to-SET, sync then async
    load_cfg("c09", 8'h09);
    lsr = 1'b1;
    #1;
    chk("lsr_sync_pre", {6'd0, q}, 8'h02);
    @(negedge clk);
    chk("lsr_sync", {6'd0, q}, 8'h03);
    lsr = 1'b0;
    ce  = 1'b1;
    di  = 2'b00;
    @(negedge clk);
    chk("clear_q", {6'd0, q}, 8'h00);
    ce = 1'b0;
    load_cfg("c89", 8'h89);
    chk("load_no_disturb", {6'd0, q}, 8'h00);
    lsr = 1'b1;
    #1;
    chk("lsr_async", {6'd0, q}, 8'h03);
    lsr = 1'b0;
    #1;
    chk("lsr_async_rel", {6'd0, q}, 8'h00);
    @(negedge clk);

    // 4: preload and DL select
    load_cfg("c24", 8'h24);
    m   = 2'b01;
    lsr = 1'b1;
    @(negedge clk);
    chk("prld", {6'd0, q}, 8'h01);
    lsr = 1'b0;
    load_cfg("c12", 8'h12);
    ce = 1'b1;
    m  = 2'b11;
    di = 2'b00;
    @(negedge clk);
    chk("sel_m", {6'd0, q}, 8'h03);
    ce = 1'b0;

    // 5: GSR enabled / disabled
    load_cfg("c40", 8'h40);
    gsr = 1'b1;
    lsr = 1'b1;
    @(negedge clk);
    chk("gsr_en", {6'd0, q}, 8'h00);
    gsr = 1'b0;
    lsr = 1'b0;
    load_cfg("c00b", 8'h00);
    gsr = 1'b1;
    ce  = 1'b1;
    di  = 2'b11;
    @(negedge clk);
    chk("gsr_dis", {6'd0, q}, 8'h03);
    ce = 1'b0;
    gsr = 1'b0;
    load_cfg("c64", 8'h64);
    gsr = 1'b1;
    lsr = 1'b1;
    m   = 2'b11;
    @(negedge clk);
    chk("gsr_over_lsr", {6'd0, q}, 8'h00);
    gsr = 1'b0;
    lsr = 1'b0;

    // 6: reset mid-frame, stray bytes
    send(8'hA5);
    send(8'h33);
    rst = 1'b1;
    #1;
    chk("midrst_ready", {7'd0, cfg_ready}, 8'd0);
    @(negedge clk);
    chk("midrst_loaded", {7'd0, cfg_loaded}, 8'd0);
    rst = 1'b0;
    chk("midrst_cfg_q", cfg_q, 8'h00);
    send(8'hA5 ^ 8'h33);
    chk("lost_frame_loaded", {7'd0, cfg_loaded}, 8'd0);
    chk("lost_frame_err", {7'd0, cfg_err}, 8'd0);
    send(8'h00);
    send(8'hFF);
    chk("stray_cfg_q", cfg_q, 8'h00);
    load_cfg("c5a", 8'h5A);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
